ppm_fb_ctrl: RTL
================

PPM_FB_CTRL -- requirements
Module: ppm_fb_ctrl

Interface
REQ-001 Parameter FRAME_WIDTH, default 100, pixels per row.
REQ-002 Parameter FRAME_HEIGHT, default 100, rows per frame.
REQ-003 clock  in  1  single clock; all logic on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  CPU store request valid.
REQ-006 req_ready  out  1  controller accepts the request this cycle.
REQ-007 req_addr  in  32  byte offset from the device base.
REQ-008 req_wdata  in  32  store data.
REQ-009 out_valid  out  1  sink command valid.
REQ-010 out_ready  in  1  sink accepts command.
REQ-011 out_address  out  32  pixel index or filename byte index.
REQ-012 out_data  out  32  pixel RGB (bits 23:0) or filename byte (bits 7:0).
REQ-013 out_operation  out  32  1 = pixel write, 2 = filename write, 0 = none.
REQ-014 dump  out  1  one-cycle frame dump strobe.
REQ-015 busy  out  1  high in any state other than IDLE.

Function
REQ-016 Address map, word-aligned: PIXEL 0x00000-0x0FFFF (index = addr>>2); NAME 0x10000-0x100FF (index = addr[7:0]); CTRL 0x20000; FILL_COLOR 0x20004; FILL_P0 0x20008 ({y0[31:16], x0[15:0]}); FILL_P1 0x2000C ({y1, x1}).
REQ-017 Handshake: a transfer occurs when valid&&ready; out_valid, out_address, out_data and out_operation hold stable until out_ready.
REQ-018 req_ready = (state==IDLE) && (!out_valid || out_ready).
REQ-019 An accepted PIXEL store with index < FRAME_WIDTH*FRAME_HEIGHT presents {index, wdata, op 1} on out_* the next cycle.
REQ-020 PIXEL stores with index >= FRAME_WIDTH*FRAME_HEIGHT, and stores to unmapped addresses, are accepted and dropped (no out_valid).
REQ-021 An accepted NAME store presents {addr[7:0], {24'b0, wdata[7:0]}, op 2} the next cycle.
REQ-022 FILL_COLOR, FILL_P0 and FILL_P1 are plain registers; they update on acceptance and generate no sink traffic.
REQ-023 CTRL write: bit1 = start fill, bit0 = dump; both set = fill, then dump; neither set = no effect.
REQ-024 FSM states IDLE, FILL, DRAIN, DUMP; IDLE->FILL on fill; IDLE->DRAIN on dump-only; FILL->DRAIN after the last fill pixel is accepted, if dump pending, else ->IDLE; DRAIN->DUMP when out_valid==0 or the sink accepts the final command; DUMP->IDLE after exactly one cycle.
REQ-025 dump is high only in DUMP, for exactly one cycle, and only after every prior command has been accepted by the sink.
REQ-026 FILL walks x0..x1 (inner loop) and y0..y1 (outer loop) inclusive, raster order, issuing index y*FRAME_WIDTH+x with FILL_COLOR, one command per sink acceptance (full throughput when out_ready stays high).
REQ-027 Fill coordinates are clamped to FRAME_WIDTH-1 and FRAME_HEIGHT-1 at start; if x0>x1 or y0>y1 after clamping, FILL issues nothing and exits the next cycle.
REQ-028 Fill registers are sampled at fill start; CPU requests stall (req_ready=0) until return to IDLE.
REQ-029 Index arithmetic uses at least 16 bits internally, zero-extended to 32 on out_address.

Reset
REQ-030 On reset: state=IDLE, out_valid=0, out_operation=0, out_address=0, out_data=0, dump=0, busy=0, FILL_COLOR=0, FILL_P0=0, FILL_P1=0, dump-pending=0.
REQ-031 Reset mid-fill or mid-drain abandons the operation immediately; no dump strobe follows.

Structure
REQ-032 Package ppm_fb_ctrl_pkg holds the op codes, address-map constants and the FSM state enum.
REQ-033 Sub-module ppm_fill_walker holds the x/y rectangle counters, clamp logic and last-pixel flag; the parent holds the FSM and output register.

Verification
REQ-034 PIXEL store addr 0x0010, data 0xFF0000, out_ready=1 -> next cycle out_valid, out_address 4, out_data 0xFF0000, out_operation 1.
REQ-035 out_ready=0 for 5 cycles on a pending command -> out_* stable, req_ready=0, and no request lost.
REQ-036 NAME store addr 0x10003, data 0x1234_5641 -> out_address 3, out_data 0x41, op 2; PIXEL index 10000 -> no out_valid.
REQ-037 Fill color 0x00FF00, P0 (2,1), P1 (4,2), CTRL=0x3 -> six writes to indices 102,103,104,202,203,204 in order, then one dump pulse, busy low afterward.
REQ-038 Fill with P0 (5,0), P1 (3,0) -> zero writes, return to IDLE; fill with P1 (200,200) -> clamped to index 9999 as the final write.
REQ-039 Reset asserted during FILL with out_ready toggling -> all outputs 0 in the following cycle, no dump pulse, new stores accepted afterward.

Source files
------------

// File: rtl/ppm_fb_ctrl_pkg.sv
// Shared definitions for the PPM frame-buffer controller: sink op codes,
// CPU address map, region decode and FSM state encoding.
package ppm_fb_ctrl_pkg;

  localparam logic [31:0] OP_NONE  = 32'd0;
  localparam logic [31:0] OP_PIXEL = 32'd1;
  localparam logic [31:0] OP_NAME  = 32'd2;

  localparam logic [31:0] ADDR_CTRL       = 32'h0002_0000;
  localparam logic [31:0] ADDR_FILL_COLOR = 32'h0002_0004;
  localparam logic [31:0] ADDR_FILL_P0    = 32'h0002_0008;
  localparam logic [31:0] ADDR_FILL_P1    = 32'h0002_000C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DRAIN,
    ST_DUMP
  } state_e;

  typedef enum logic [2:0] {
    RG_PIXEL,
    RG_NAME,
    RG_CTRL,
    RG_COLOR,
    RG_P0,
    RG_P1,
    RG_NONE
  } region_e;

  function automatic region_e decode_addr(input logic [31:0] addr);
    region_e rg;
    rg = RG_NONE;
    if (addr[31:16] == 16'h0000)       rg = RG_PIXEL;
    else if (addr[31:8] == 24'h000100) rg = RG_NAME;
    else if (addr == ADDR_CTRL)        rg = RG_CTRL;
    else if (addr == ADDR_FILL_COLOR)  rg = RG_COLOR;
    else if (addr == ADDR_FILL_P0)     rg = RG_P0;
    else if (addr == ADDR_FILL_P1)     rg = RG_P1;
    return rg;
  endfunction

endpackage

// File: rtl/ppm_fill_walker.sv
// Rectangle walker for FILL: clamps the corners at start, then steps x
// (inner) and y (outer) in raster order, exposing the pixel index.
module ppm_fill_walker #(
  parameter int FRAME_WIDTH  = 100,
  parameter int FRAME_HEIGHT = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        advance,
  input  logic [31:0] p0,
  input  logic [31:0] p1,
  output logic [31:0] index,
  output logic        last,
  output logic        empty
);

  localparam logic [15:0] X_MAX = 16'(FRAME_WIDTH - 1);
  localparam logic [15:0] Y_MAX = 16'(FRAME_HEIGHT - 1);

  function automatic logic [15:0] clamp(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  logic [15:0] cx0, cy0, cx1, cy1;
  logic [15:0] x, y, x_lo, x_hi, y_hi;

  assign cx0 = clamp(p0[15:0],  X_MAX);
  assign cy0 = clamp(p0[31:16], Y_MAX);
  assign cx1 = clamp(p1[15:0],  X_MAX);
  assign cy1 = clamp(p1[31:16], Y_MAX);

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      x     <= '0;
      y     <= '0;
      x_lo  <= '0;
      x_hi  <= '0;
      y_hi  <= '0;
      empty <= 1'b1;
    end else if (start) begin
      x     <= cx0;
      y     <= cy0;
      x_lo  <= cx0;
      x_hi  <= cx1;
      y_hi  <= cy1;
      empty <= (cx0 > cx1) || (cy0 > cy1);
    end else if (advance) begin
      if (x == x_hi) begin
        x <= x_lo;
        y <= y + 16'd1;
      end else begin
        x <= x + 16'd1;
      end
    end
  end

  assign last  = (x == x_hi) && (y == y_hi);
  assign index = 32'(y) * 32'(FRAME_WIDTH) + 32'(x);

endmodule

// File: rtl/ppm_fb_ctrl.sv
// PPM frame-buffer controller: turns CPU stores into pixel/filename sink
// commands, runs rectangle fills and issues a frame dump strobe.
module ppm_fb_ctrl
  import ppm_fb_ctrl_pkg::*;
#(
  parameter int FRAME_WIDTH  = 100,
  parameter int FRAME_HEIGHT = 100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_address,
  output logic [31:0] out_data,
  output logic [31:0] out_operation,
  output logic        dump,
  output logic        busy
);

  localparam logic [31:0] NUM_PIXELS = 32'(FRAME_WIDTH * FRAME_HEIGHT);

  state_e      state, state_next;
  logic [23:0] fill_color;
  logic [31:0] fill_p0, fill_p1;
  logic        dump_pending;

  logic        slot_free;
  logic        load_cmd;
  logic [31:0] cmd_addr, cmd_data, cmd_op;
  logic        walk_start, walk_advance, walk_last, walk_empty;
  logic [31:0] walk_index;
  logic        wr_color, wr_p0, wr_p1, set_pending, clr_pending;
  logic [31:0] pix_index;

  ppm_fill_walker #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .FRAME_HEIGHT(FRAME_HEIGHT)
  ) u_walker (
    .clock  (clock),
    .reset  (reset),
    .start  (walk_start),
    .advance(walk_advance),
    .p0     (fill_p0),
    .p1     (fill_p1),
    .index  (walk_index),
    .last   (walk_last),
    .empty  (walk_empty)
  );

  assign slot_free = !out_valid || out_ready;
  assign pix_index = {2'b00, req_addr[31:2]};

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    state_next   = state;
    req_ready    = 1'b0;
    load_cmd     = 1'b0;
    cmd_addr     = '0;
    cmd_data     = '0;
    cmd_op       = OP_NONE;
    walk_start   = 1'b0;
    walk_advance = 1'b0;
    wr_color     = 1'b0;
    wr_p0        = 1'b0;
    wr_p1        = 1'b0;
    set_pending  = 1'b0;
    clr_pending  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = slot_free;
        if (req_valid && slot_free) begin
          unique case (decode_addr(req_addr))
            RG_PIXEL: if (pix_index < NUM_PIXELS) begin
              load_cmd = 1'b1;
              cmd_addr = pix_index;
              cmd_data = req_wdata;
              cmd_op   = OP_PIXEL;
            end
            RG_NAME: begin
              load_cmd = 1'b1;
              cmd_addr = {24'b0, req_addr[7:0]};
              cmd_data = {24'b0, req_wdata[7:0]};
              cmd_op   = OP_NAME;
            end
            RG_CTRL: begin
              if (req_wdata[1]) begin
                walk_start  = 1'b1;
                set_pending = 1'b1;
                state_next  = ST_FILL;
              end else if (req_wdata[0]) begin
                state_next = ST_DRAIN;
              end
            end
            RG_COLOR: wr_color = 1'b1;
            RG_P0:    wr_p0    = 1'b1;
            RG_P1:    wr_p1    = 1'b1;
            default: ;
          endcase
        end
      end
      ST_FILL: begin
        if (walk_empty) begin
          state_next = dump_pending ? ST_DRAIN : ST_IDLE;
        end else if (slot_free) begin
          load_cmd     = 1'b1;
          cmd_addr     = walk_index;
          cmd_data     = {8'b0, fill_color};
          cmd_op       = OP_PIXEL;
          walk_advance = 1'b1;
          if (walk_last) state_next = dump_pending ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (slot_free) begin
          clr_pending = 1'b1;
          state_next  = ST_DUMP;
        end
      end
      ST_DUMP: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_address   <= '0;
      out_data      <= '0;
      out_operation <= OP_NONE;
    end else if (load_cmd) begin
      out_valid     <= 1'b1;
      out_address   <= cmd_addr;
      out_data      <= cmd_data;
      out_operation <= cmd_op;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
      out_operation <= OP_NONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fill_color   <= '0;
      fill_p0      <= '0;
      fill_p1      <= '0;
      dump_pending <= 1'b0;
    end else begin
      if (wr_color) fill_color <= req_wdata[23:0];
      if (wr_p0)    fill_p0    <= req_wdata;
      if (wr_p1)    fill_p1    <= req_wdata;
      if (set_pending)      dump_pending <= req_wdata[0];
      else if (clr_pending) dump_pending <= 1'b0;
    end
  end

  assign dump = (state == ST_DUMP);
  assign busy = (state != ST_IDLE);

endmodule
